// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Byte-stream program loader: the write side of a byte-addressed, little-endian
// instruction memory. A frame is LEN (word count N), then 4N payload bytes
// (word 0 LSB first), then CHK (XOR of all payload bytes). Each accepted
// payload byte becomes one memory byte write on the following cycle. The CPU
// is held in reset while a frame is loading and after a failed load.
//
// Ports:
//   clk                  in   clock, all logic on posedge
//   rst                  in   synchronous active-high reset
//   i_imem_loader_data   in   [7:0]  stream byte
//   i_imem_loader_valid  in          stream byte valid
//   o_imem_loader_ready  out         loader can accept a byte (registered)
//   i_imem_loader_clear  in          leave the error state
//   o_imem_loader_we     out         memory byte write enable
//   o_imem_loader_addr   out  [ADDR_W-1:0] memory byte address
//   o_imem_loader_wdata  out  [7:0]  memory write byte
//   o_imem_loader_hold   out         CPU reset request
//   o_imem_loader_done   out         one-cycle pulse on a good load
//   o_imem_loader_err    out         sticky error flag
//   o_imem_loader_count  out  [ADDR_W-1:0] payload bytes accepted this frame
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int unsigned       ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       MAX_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        i_imem_loader_data,
    input  logic              i_imem_loader_valid,
    output logic              o_imem_loader_ready,
    input  logic              i_imem_loader_clear,
    output logic              o_imem_loader_we,
    output logic [ADDR_W-1:0] o_imem_loader_addr,
    output logic [7:0]        o_imem_loader_wdata,
    output logic              o_imem_loader_hold,
    output logic              o_imem_loader_done,
    output logic              o_imem_loader_err,
    output logic [ADDR_W-1:0] o_imem_loader_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] last_cnt;   // count value of the final payload byte (4N-1)
    logic [7:0]        xor_acc;    // running XOR of payload bytes

    // ready is a registered output, so the transfer qualifier never forms a
    // combinational path from valid back to ready.
    logic xfer;
    assign xfer = i_imem_loader_valid & o_imem_loader_ready;

    // LEN range check is done in a widened domain so that BASE_ADDR + 4N can
    // be compared against the memory size without overflow (N is up to 255,
    // so 4N needs 10 bits on top of the address width).
    localparam int unsigned     EXT_W     = ADDR_W + 11;
    localparam logic [EXT_W-1:0] MEM_BYTES = {10'b0, 1'b1, {ADDR_W{1'b0}}};

    logic [EXT_W-1:0] len_bytes;
    logic [EXT_W-1:0] frame_end;
    logic [EXT_W-1:0] len_last;
    logic             len_bad;

    assign len_bytes = {{(ADDR_W+1){1'b0}}, i_imem_loader_data, 2'b00};
    assign frame_end = {11'b0, BASE_ADDR} + len_bytes;
    assign len_last  = len_bytes - EXT_W'(1);
    assign len_bad   = (i_imem_loader_data == 8'd0)
                     | (32'(i_imem_loader_data) > MAX_WORDS)
                     | (frame_end > MEM_BYTES);

    // Upper bits of len_last are always zero for an accepted LEN (the range
    // check guarantees 4N-1 fits in ADDR_W bits); they are deliberately dropped.
    logic unused_len_hi;
    assign unused_len_hi = ^len_last[EXT_W-1:ADDR_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= S_IDLE;
            o_imem_loader_ready <= 1'b1;
            o_imem_loader_we    <= 1'b0;
            o_imem_loader_addr  <= BASE_ADDR;
            o_imem_loader_wdata <= 8'd0;
            o_imem_loader_hold  <= 1'b0;
            o_imem_loader_done  <= 1'b0;
            o_imem_loader_err   <= 1'b0;
            o_imem_loader_count <= '0;
            last_cnt            <= '0;
            xor_acc             <= 8'd0;
        end else begin
            // we and done are single-cycle strobes.
            o_imem_loader_we   <= 1'b0;
            o_imem_loader_done <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (xfer) begin
                        o_imem_loader_hold <= 1'b1;
                        if (len_bad) begin
                            state               <= S_ERR;
                            o_imem_loader_ready <= 1'b0;
                            o_imem_loader_err   <= 1'b1;
                        end else begin
                            state               <= S_DATA;
                            last_cnt            <= len_last[ADDR_W-1:0];
                            o_imem_loader_count <= '0;
                            xor_acc             <= 8'd0;
                        end
                    end
                end

                S_DATA: begin
                    if (xfer) begin
                        // Write issues from the pre-increment count; the LEN
                        // check guarantees BASE_ADDR + count never wraps.
                        o_imem_loader_we    <= 1'b1;
                        o_imem_loader_addr  <= BASE_ADDR + o_imem_loader_count;
                        o_imem_loader_wdata <= i_imem_loader_data;
                        o_imem_loader_count <= o_imem_loader_count + ADDR_W'(1);
                        xor_acc             <= xor_acc ^ i_imem_loader_data;
                        if (o_imem_loader_count == last_cnt)
                            state <= S_CHK;
                    end
                end

                S_CHK: begin
                    // The final payload write is on the bus during this state.
                    if (xfer) begin
                        o_imem_loader_ready <= 1'b0;
                        if ((xor_acc ^ i_imem_loader_data) == 8'd0) begin
                            state              <= S_DONE;
                            o_imem_loader_done <= 1'b1;
                            o_imem_loader_hold <= 1'b0;
                        end else begin
                            state             <= S_ERR;
                            o_imem_loader_err <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    state               <= S_IDLE;
                    o_imem_loader_ready <= 1'b1;
                end

                S_ERR: begin
                    // Stream bytes are ignored (ready is low); only clear exits.
                    if (i_imem_loader_clear) begin
                        state               <= S_IDLE;
                        o_imem_loader_ready <= 1'b1;
                        o_imem_loader_err   <= 1'b0;
                        o_imem_loader_hold  <= 1'b0;
                    end
                end

                default: begin
                    state               <= S_IDLE;
                    o_imem_loader_ready <= 1'b1;
                    o_imem_loader_hold  <= 1'b0;
                    o_imem_loader_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       rst;

    // DUT with default parameters (BASE_ADDR = 0)
    logic [7:0] d_data;
    logic       d_valid, d_clear;
    logic       d_ready, d_we, d_hold, d_done, d_err;
    logic [7:0] d_addr, d_wdata, d_count;

    // DUT with BASE_ADDR = 200 for the address-range check
    logic [7:0] hi_data;
    logic       hi_valid, hi_clear;
    logic       hi_ready, hi_we, hi_hold, hi_done, hi_err;
    logic [7:0] hi_addr, hi_wdata, hi_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_loader dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_imem_loader_data  (d_data),
        .i_imem_loader_valid (d_valid),
        .o_imem_loader_ready (d_ready),
        .i_imem_loader_clear (d_clear),
        .o_imem_loader_we    (d_we),
        .o_imem_loader_addr  (d_addr),
        .o_imem_loader_wdata (d_wdata),
        .o_imem_loader_hold  (d_hold),
        .o_imem_loader_done  (d_done),
        .o_imem_loader_err   (d_err),
        .o_imem_loader_count (d_count)
    );

    imem_loader #(.ADDR_W(8), .BASE_ADDR(8'd200), .MAX_WORDS(64)) dut_hi (
        .clk                 (clk),
        .rst                 (rst),
        .i_imem_loader_data  (hi_data),
        .i_imem_loader_valid (hi_valid),
        .o_imem_loader_ready (hi_ready),
        .i_imem_loader_clear (hi_clear),
        .o_imem_loader_we    (hi_we),
        .o_imem_loader_addr  (hi_addr),
        .o_imem_loader_wdata (hi_wdata),
        .o_imem_loader_hold  (hi_hold),
        .o_imem_loader_done  (hi_done),
        .o_imem_loader_err   (hi_err),
        .o_imem_loader_count (hi_count)
    );

    // Write/done monitor, sampled on the falling edge.
    int         cyc = 0;
    logic [7:0] wa[$];
    logic [7:0] wd[$];
    int         wc[$];
    int         done_n = 0;
    int         hi_we_n = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (d_we) begin
            wa.push_back(d_addr);
            wd.push_back(d_wdata);
            wc.push_back(cyc);
        end
        if (d_done)
            done_n <= done_n + 1;
        if (hi_we)
            hi_we_n <= hi_we_n + 1;
    end

    // One byte transfer: raise valid, wait for ready, take one edge.
    task automatic xfer(input bit hi, input logic [7:0] b);
        int t = 0;
        if (hi) begin hi_data = b; hi_valid = 1'b1; end
        else    begin d_data  = b; d_valid  = 1'b1; end
        while (((hi ? hi_ready : d_ready) !== 1'b1) && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 40) begin
            checks++; errors++;
            $display("FAIL xfer_timeout byte=%02h ready=0 required=1", b);
        end
        @(posedge clk); #1;
        hi_valid = 1'b0;
        d_valid  = 1'b0;
    endtask

    task automatic pulse_clear(input bit hi);
        if (hi) hi_clear = 1'b1; else d_clear = 1'b1;
        @(posedge clk); #1;
        hi_clear = 1'b0;
        d_clear  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        d_valid = 0; d_clear = 0; d_data = 0;
        hi_valid = 0; hi_clear = 0; hi_data = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({d_ready, d_we, d_addr, d_wdata, d_hold, d_done, d_err, d_count}
            !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_values rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b cnt=%h required 1 0 00 00 0 0 0 00",
                     d_ready, d_we, d_addr, d_wdata, d_hold, d_done, d_err, d_count);
        end
        checks++;
        if ({hi_ready, hi_we, hi_addr, hi_wdata, hi_hold, hi_done, hi_err, hi_count}
            !== {1'b1, 1'b0, 8'd200, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_values_hi rdy=%b we=%b addr=%0d wd=%h hold=%b done=%b err=%b cnt=%h required 1 0 200 00 0 0 0 00",
                     hi_ready, hi_we, hi_addr, hi_wdata, hi_hold, hi_done, hi_err, hi_count);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        logic [7:0] pl[4] = '{8'h00, 8'h00, 8'h04, 8'h8C};
        int b0 = wa.size();
        int dn0 = done_n;
        xfer(0, 8'd1);
        checks++;
        if (d_hold !== 1'b1) begin
            errors++; $display("FAIL basic_hold_after_len hold=%b required=1", d_hold);
        end
        for (int i = 0; i < 4; i++) xfer(0, pl[i]);
        checks++;
        if (d_hold !== 1'b1) begin
            errors++; $display("FAIL basic_hold_in_chk hold=%b required=1", d_hold);
        end
        xfer(0, 8'h88);
        checks++;
        if ({d_done, d_hold, d_ready, d_err} !== 4'b1000) begin
            errors++;
            $display("FAIL basic_done_state done,hold,ready,err=%b required=1000", {d_done, d_hold, d_ready, d_err});
        end
        @(posedge clk); #1;
        checks++;
        if ({d_done, d_ready} !== 2'b01) begin
            errors++; $display("FAIL basic_back_to_idle done,ready=%b required=01", {d_done, d_ready});
        end
        checks++;
        if (wa.size() - b0 !== 4) begin
            errors++; $display("FAIL basic_write_count got=%0d required=4", wa.size() - b0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wa[b0+i] !== 8'(i) || wd[b0+i] !== pl[i] || wc[b0+i] !== wc[b0] + i) begin
                    errors++;
                    $display("FAIL basic_write%0d addr=%h data=%h cyc+%0d required addr=%h data=%h cyc+%0d",
                             i, wa[b0+i], wd[b0+i], wc[b0+i] - wc[b0], 8'(i), pl[i], i);
                end
            end
        end
        checks++;
        if (done_n - dn0 !== 1) begin
            errors++; $display("FAIL basic_done_pulses got=%0d required=1", done_n - dn0);
        end
    endtask

    task automatic test_len_zero;
        int b0 = wa.size();
        xfer(0, 8'd0);
        checks++;
        if ({d_err, d_hold, d_ready} !== 3'b110) begin
            errors++; $display("FAIL len0_err err,hold,ready=%b required=110", {d_err, d_hold, d_ready});
        end
        d_data = 8'h55; d_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        d_valid = 1'b0;
        checks++;
        if (wa.size() !== b0 || {d_err, d_ready} !== 2'b10) begin
            errors++;
            $display("FAIL len0_ignore writes=%0d err,ready=%b required writes=0 err,ready=10", wa.size() - b0, {d_err, d_ready});
        end
        pulse_clear(0);
        checks++;
        if ({d_err, d_hold, d_ready} !== 3'b001) begin
            errors++; $display("FAIL len0_clear err,hold,ready=%b required=001", {d_err, d_hold, d_ready});
        end
    endtask

    task automatic test_bad_chk;
        logic [7:0] pl[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        int b0 = wa.size();
        int dn0 = done_n;
        xfer(0, 8'd2);
        for (int i = 0; i < 8; i++) begin
            // clear must be ignored outside ERR
            if (i == 3) d_clear = 1'b1;
            xfer(0, pl[i]);
            d_clear = 1'b0;
        end
        xfer(0, 8'h89);   // correct XOR is 88
        checks++;
        if ({d_err, d_hold, d_ready, d_done} !== 4'b1100) begin
            errors++; $display("FAIL badchk_err err,hold,ready,done=%b required=1100", {d_err, d_hold, d_ready, d_done});
        end
        checks++;
        if (wa.size() - b0 !== 8) begin
            errors++; $display("FAIL badchk_write_count got=%0d required=8", wa.size() - b0);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (wa[b0+i] !== 8'(i) || wd[b0+i] !== pl[i]) begin
                    errors++;
                    $display("FAIL badchk_write%0d addr=%h data=%h required addr=%h data=%h", i, wa[b0+i], wd[b0+i], 8'(i), pl[i]);
                end
            end
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (done_n !== dn0 || d_err !== 1'b1) begin
            errors++; $display("FAIL badchk_no_done done_pulses=%0d err=%b required 0 1", done_n - dn0, d_err);
        end
        pulse_clear(0);
    endtask

    task automatic test_gaps;
        logic [7:0] pl[64];
        logic [7:0] x = 8'h00;
        int b0 = wa.size();
        int dn0 = done_n;
        int bad = 0;
        for (int i = 0; i < 64; i++) begin
            pl[i] = 8'(i * 37 + 5);
            x = x ^ pl[i];
        end
        xfer(0, 8'd16);
        for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
            xfer(0, pl[i]);
        end
        xfer(0, x);
        @(posedge clk); #1;
        checks++;
        if (wa.size() - b0 !== 64) begin
            errors++; $display("FAIL gaps_write_count got=%0d required=64", wa.size() - b0);
        end else begin
            for (int i = 0; i < 64; i++)
                if (wa[b0+i] !== 8'(i) || wd[b0+i] !== pl[i]) bad++;
            checks++;
            if (bad !== 0) begin
                errors++; $display("FAIL gaps_write_order bad_entries=%0d required=0", bad);
            end
        end
        checks++;
        if (done_n - dn0 !== 1 || d_err !== 1'b0) begin
            errors++; $display("FAIL gaps_done pulses=%0d err=%b required 1 0", done_n - dn0, d_err);
        end
    endtask

    task automatic test_len_limits;
        int b0 = wa.size();
        int h0 = hi_we_n;
        xfer(0, 8'd65);
        @(posedge clk); #1;
        checks++;
        if ({d_err, d_hold, d_ready} !== 3'b110 || wa.size() !== b0) begin
            errors++;
            $display("FAIL len65_err err,hold,ready=%b writes=%0d required 110 0", {d_err, d_hold, d_ready}, wa.size() - b0);
        end
        pulse_clear(0);
        xfer(1, 8'd15);   // 200 + 60 > 256
        @(posedge clk); #1;
        checks++;
        if ({hi_err, hi_hold, hi_ready} !== 3'b110 || hi_we_n !== h0) begin
            errors++;
            $display("FAIL hi_len15_err err,hold,ready=%b writes=%0d required 110 0", {hi_err, hi_hold, hi_ready}, hi_we_n - h0);
        end
        pulse_clear(1);
        xfer(1, 8'd14);   // 200 + 56 == 256 fits exactly
        checks++;
        if ({hi_err, hi_hold, hi_ready} !== 3'b011) begin
            errors++; $display("FAIL hi_len14_accept err,hold,ready=%b required=011", {hi_err, hi_hold, hi_ready});
        end
        xfer(0, 8'd64);   // MAX_WORDS fills the whole memory
        checks++;
        if ({d_err, d_hold, d_ready} !== 3'b011) begin
            errors++; $display("FAIL len64_accept err,hold,ready=%b required=011", {d_err, d_hold, d_ready});
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({d_hold, hi_hold, d_ready, hi_ready} !== 4'b0011) begin
            errors++; $display("FAIL limits_reset hold,hihold,ready,hiready=%b required=0011", {d_hold, hi_hold, d_ready, hi_ready});
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] pl[4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        int b0;
        int dn0 = done_n;
        xfer(0, 8'd4);
        for (int i = 0; i < 5; i++) xfer(0, 8'(8'h30 + i));
        // reset wins over a simultaneous transfer
        d_data = 8'h99; d_valid = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; d_valid = 1'b0;
        checks++;
        if ({d_ready, d_we, d_addr, d_wdata, d_hold, d_done, d_err, d_count}
            !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL midreset_values rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b cnt=%h required 1 0 00 00 0 0 0 00",
                     d_ready, d_we, d_addr, d_wdata, d_hold, d_done, d_err, d_count);
        end
        b0 = wa.size();
        xfer(0, 8'd1);
        for (int i = 0; i < 4; i++) xfer(0, pl[i]);
        xfer(0, 8'h04);
        @(posedge clk); #1;
        checks++;
        if (wa.size() - b0 !== 4) begin
            errors++; $display("FAIL midreset_write_count got=%0d required=4", wa.size() - b0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wa[b0+i] !== 8'(i) || wd[b0+i] !== pl[i]) begin
                    errors++;
                    $display("FAIL midreset_write%0d addr=%h data=%h required addr=%h data=%h", i, wa[b0+i], wd[b0+i], 8'(i), pl[i]);
                end
            end
        end
        checks++;
        if (done_n - dn0 !== 1 || d_err !== 1'b0) begin
            errors++; $display("FAIL midreset_done pulses=%0d err=%b required 1 0", done_n - dn0, d_err);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_len_zero;
        test_bad_chk;
        test_gaps;
        test_len_limits;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1);
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader: the write side of the byte-addressed, little-endian instruction memory.
- Accepts a framed byte stream over a valid/ready handshake and issues byte writes (LSB of each word at the lowest address).
- Verifies a checksum at the end of the frame.
- Holds the CPU in reset while loading and after a failed load.

Parameters:
- ADDR_W, 8, instruction-memory byte address width (256 bytes).
- BASE_ADDR, 0, first byte address written.
- MAX_WORDS, 64, largest accepted word count per frame.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- i_imem_loader_data  in  8  stream byte.
- i_imem_loader_valid  in  1  stream byte valid.
- o_imem_loader_ready  out  1  loader can accept a byte; transfer = valid & ready on a posedge.
- i_imem_loader_clear  in  1  leave ERR state.
- o_imem_loader_we  out  1  instruction-memory byte write enable.
- o_imem_loader_addr  out  ADDR_W  write byte address.
- o_imem_loader_wdata  out  8  write byte.
- o_imem_loader_hold  out  1  CPU reset request.
- o_imem_loader_done  out  1  one-cycle pulse on a good load.
- o_imem_loader_err  out  1  sticky error flag.
- o_imem_loader_count  out  ADDR_W  data bytes accepted in the current frame.

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (rst); the polarity and synchronicity are fixed.
- Reset values: state IDLE. ready=1, we=0, addr=BASE_ADDR, wdata=0, hold=0, done=0, err=0, count=0.
- Reset mid-frame: abandons the frame immediately. Bytes already written stay in memory. No done or err is reported.
- Frame format: LEN byte (N words), then 4N payload bytes, then CHK byte.
  - Payload order: word 0 byte 0 (LSB) first, then byte1, byte2, byte3, then word 1, and so on.
  - CHK equals the XOR of all 4N payload bytes.
- IDLE:
  - ready=1, hold=0.
  - On LEN transfer: if N==0, N>MAX_WORDS, or BASE_ADDR+4N > 2^ADDR_W, go to ERR.
  - Otherwise latch N, clear the running XOR and count, set hold=1, go to DATA.
- DATA:
  - ready=1.
  - Each transfer produces one write on the next cycle: we=1, addr=BASE_ADDR+count, wdata=byte. Then count increments and XOR accumulates.
  - Write latency is exactly 1 cycle. we is high only the cycle after a transfer; back-to-back transfers give back-to-back writes.
  - When the transfer with count==4N-1 occurs, go to CHK.
- CHK:
  - ready=1.
  - On transfer: if XOR^byte==0, go to DONE; else go to ERR.
  - The last payload write completes during this state.
- DONE (one cycle):
  - ready=0, done=1, hold=0 from this cycle.
  - Returns to IDLE.
- ERR:
  - ready=0, err=1, hold=1; incoming bytes are ignored.
  - i_imem_loader_clear moves to IDLE (err=0, hold=0) on the next cycle.
  - clear is ignored in every other state.
- Handshake rules:
  - valid low with ready high is a stall: no state change, we=0.
  - The stream side may hold valid continuously.
  - ready does not depend combinationally on valid.
- Arithmetic:
  - The address add is ADDR_W-bit and never wraps, because the LEN check guarantees the range fits.
  - count is ADDR_W-bit.
  - XOR is 8-bit.
- Simultaneous events: rst has priority over clear and over any transfer.

Test Plan:
- Reset, then stream LEN=1, 8C 04 00 00 (LSB first: 00,00,04,8C), CHK=8C^04=88 -> writes at addr 0..3 of 00,00,04,8C on consecutive cycles; hold high from the cycle after LEN until DONE; done pulses once; err=0.
- LEN=0 -> err=1, hold=1, ready=0; later bytes are ignored. Pulse clear -> IDLE, err=0, ready=1.
- LEN=2 with 8 payload bytes and a wrong CHK (correct XOR ^ 01) -> all 8 writes occur at addr 0..7, then err=1, done never asserted.
- Randomized valid gaps (valid toggling 50%) on a 16-word frame -> exactly 64 writes in address order 0..63 with no duplicates; done pulses once.
- LEN=65 (MAX_WORDS+1) -> ERR with no write; with BASE_ADDR=200 and LEN=15 (exceeds 256 bytes) -> ERR.
- Assert rst after 5 payload bytes of a LEN=4 frame -> next cycle shows all reset values; a fresh frame then loads correctly from addr BASE_ADDR.
